div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one repeated-subtraction divider between two requesters.
- Accepts a dividend/divisor job on a valid/ready channel and sequences the divider through load, clear, subtract and increment steps.
- Returns quotient and remainder to the granted requester on a valid/ready response channel.
- Sits between client blocks and the division datapath; it is the single owner of the divider's control signals.

Parameters:
- WIDTH, 16, operand, quotient and remainder width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-channel job request.
- req_ready  out  2  per-channel job accept; at most one bit high.
- req_dividend0  in  WIDTH  channel 0 dividend.
- req_divisor0  in  WIDTH  channel 0 divisor.
- req_dividend1  in  WIDTH  channel 1 dividend.
- req_divisor1  in  WIDTH  channel 1 divisor.
- rsp_valid  out  2  per-channel result valid; at most one bit high.
- rsp_ready  in  2  per-channel result accept.
- rsp_quotient  out  WIDTH  quotient, qualified by rsp_valid.
- rsp_remainder  out  WIDTH  remainder, qualified by rsp_valid.
- rsp_divzero  out  1  divide-by-zero flag, qualified by rsp_valid.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  channel currently owning the divider.

Behaviour:
- Reset (asynchronous, immediate, including mid-operation):
  - State goes to IDLE.
  - req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_divzero, busy and grant_id all go to 0.
  - last_grant goes to 1, so channel 0 wins the first contention.
  - Any in-flight job is discarded.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - Winner: the requesting channel if only one req_valid is set. If both are set, the channel != last_grant wins.
  - req_ready[winner] is driven combinationally in the same cycle.
  - On the handshake: capture the winner's operands, set grant_id and last_grant to the winner, go to LOAD.
  - With no requests, stay in IDLE.
- LOAD (1 cycle):
  - P <= dividend, N <= divisor, Q <= 0.
  - If divisor == 0: go to RESP with rsp_divzero=1, quotient all ones, remainder = dividend.
  - Otherwise go to RUN.
- RUN:
  - Each cycle P >= N: P <= P - N and Q <= Q + 1.
  - First cycle P < N: go to RESP. Remainder = P (always < divisor), quotient = Q.
- RESP:
  - rsp_valid[grant_id] = 1; data held stable until rsp_ready[grant_id].
  - On the handshake go to IDLE; rsp_valid drops the next cycle.
  - No request is accepted in RESP (no bypass). req_ready = 0 in LOAD, RUN and RESP.
- Latency, with the request handshake at cycle 0:
  - Normal job: rsp_valid rises at cycle Q+3.
  - Divide-by-zero job: rsp_valid rises at cycle 2.
  - Next grant possible in the cycle after the response handshake.
- Width rules:
  - All arithmetic is unsigned WIDTH-bit.
  - Q never overflows, because Q <= dividend.
  - Worst case is 2^WIDTH - 1 divided by 1.
- Boundary cases:
  - dividend < divisor gives Q=0, R=dividend.
  - dividend == divisor gives Q=1, R=0.
  - A requester deasserting req_valid before it is granted is simply not served; no state is kept for it.
  - rsp_ready on a non-granted channel is ignored.

Decomposition:
- Shared package: state encoding constants (IDLE, LOAD, RUN, RESP) and the default WIDTH.
- One natural sub-module, div_rs_core: the datapath.
  - Holds the P, N and Q registers.
  - Inputs: load_p, load_n, clear_q, inc_q, sub_p.
  - Output: p_ge_n flag.
- div_share_arbiter holds the FSM, round-robin pointer and handshake logic, and drives div_rs_core's controls.

Test Plan:
- Single job: channel 0, 100 / 7 -> rsp_valid[0] at cycle 17, quotient 14, remainder 2, divzero 0, busy high in cycles 1..17.
- Divide by zero: channel 1, 55 / 0 -> rsp_valid[1] at cycle 2, quotient 0xFFFF, remainder 55, divzero 1.
- Contention: both channels hold req_valid from reset with 20/4 and 9/3, and both re-request after each response -> grant order 0, 1, 0, 1. Results 5 R0 and 3 R0; req_ready never has both bits high.
- Backpressure: 3 / 10 with rsp_ready low for 10 cycles -> rsp_valid[0] at cycle 3 and held, quotient 0, remainder 3 stable throughout. req_ready stays 0 even though channel 1 is requesting; channel 1 is granted the cycle after rsp_ready rises.
- Extremes: 65535 / 1 -> quotient 65535, remainder 0 at cycle 65538; 65535 / 65535 -> quotient 1, remainder 0 at cycle 4.
- Reset mid-RUN: start 65535 / 1, assert rst_n low at cycle 50 -> all outputs 0 immediately with no clock edge needed. After release, with both channels requesting, channel 0 is granted first.

Source files
------------

// File: rtl/div_share_arbiter_pkg.sv
// div_share_arbiter_pkg: shared state encoding and default width for the divider arbiter.
package div_share_arbiter_pkg;
    localparam int DEF_WIDTH = 16;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;
endpackage

// File: rtl/div_rs_core.sv
// div_rs_core: repeated-subtraction datapath holding partial remainder, divisor and quotient.
module div_rs_core
    import div_share_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_p,
    input  logic             load_n,
    input  logic             clear_q,
    input  logic             inc_q,
    input  logic             sub_p,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] q,
    output logic             p_ge_n
);
    logic [WIDTH-1:0] n;

    assign p_ge_n = p >= n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
            n <= '0;
            q <= '0;
        end else begin
            if (load_p)
                p <= dividend;
            else if (sub_p)
                p <= p - n;
            if (load_n)
                n <= divisor;
            if (clear_q)
                q <= '0;
            else if (inc_q)
                q <= q + 1'b1;
        end
    end
endmodule

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin owner of one repeated-subtraction divider shared by two clients.
module div_share_arbiter
    import div_share_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_dividend0,
    input  logic [WIDTH-1:0] req_divisor0,
    input  logic [WIDTH-1:0] req_dividend1,
    input  logic [WIDTH-1:0] req_divisor1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_divzero,
    output logic             busy,
    output logic             grant_id
);
    state_t           state;
    logic             last_grant;
    logic             win;
    logic             ld;
    logic             step;
    logic             p_ge_n;
    logic [WIDTH-1:0] op_dividend;
    logic [WIDTH-1:0] op_divisor;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;

    // On contention the channel that did not win last time gets the divider.
    assign win  = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign ld   = state == LOAD;
    assign step = (state == RUN) && p_ge_n;

    // Gated by rst_n so ready reads low while reset is held, not only after it.
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && state == IDLE && |req_valid)
            req_ready = win ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            grant_id      <= 1'b0;
            busy          <= 1'b0;
            rsp_valid     <= 2'b00;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_divzero   <= 1'b0;
            op_dividend   <= '0;
            op_divisor    <= '0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    state       <= LOAD;
                    busy        <= 1'b1;
                    grant_id    <= win;
                    last_grant  <= win;
                    op_dividend <= win ? req_dividend1 : req_dividend0;
                    op_divisor  <= win ? req_divisor1 : req_divisor0;
                end
                LOAD: if (op_divisor == '0) begin
                    state         <= RESP;
                    rsp_valid     <= grant_id ? 2'b10 : 2'b01;
                    rsp_quotient  <= '1;
                    rsp_remainder <= op_dividend;
                    rsp_divzero   <= 1'b1;
                end else begin
                    state <= RUN;
                end
                RUN: if (!p_ge_n) begin
                    state         <= RESP;
                    rsp_valid     <= grant_id ? 2'b10 : 2'b01;
                    rsp_quotient  <= q;
                    rsp_remainder <= p;
                    rsp_divzero   <= 1'b0;
                end
                RESP: if (rsp_ready[grant_id]) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    rsp_valid <= 2'b00;
                end
                default: state <= IDLE;
            endcase
        end
    end

    div_rs_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_p  (ld),
        .load_n  (ld),
        .clear_q (ld),
        .inc_q   (step),
        .sub_p   (step),
        .dividend(op_dividend),
        .divisor (op_divisor),
        .p       (p),
        .q       (q),
        .p_ge_n  (p_ge_n)
    );
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: directed and random jobs checked against an arithmetic reference model.
module tb_div_share_arbiter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   rsp_ready = 2'b00;
    logic [W-1:0] dvd0 = '0, dvs0 = '0, dvd1 = '0, dvs1 = '0;
    logic [1:0]   req_ready, rsp_valid;
    logic [W-1:0] rsp_quotient, rsp_remainder;
    logic         rsp_divzero, busy, grant_id;

    int   checks = 0;
    int   fails = 0;
    logic lg = 1'b1;
    logic ch;
    int   w;

    div_share_arbiter #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend0(dvd0),
        .req_divisor0 (dvs0),
        .req_dividend1(dvd1),
        .req_divisor1 (dvs1),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_quotient (rsp_quotient),
        .rsp_remainder(rsp_remainder),
        .rsp_divzero  (rsp_divzero),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_quotient"}, 32'(rsp_quotient), 0);
        chk({tag, "_remainder"}, 32'(rsp_remainder), 0);
        chk({tag, "_divzero"}, 32'(rsp_divzero), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_grant_id"}, 32'(grant_id), 0);
    endtask

    // Waits for a grant, checks it against the round-robin model, then completes the handshake.
    task automatic wait_grant(input logic [1:0] pat, input logic [1:0] after,
                              output logic exp_ch, output int waited);
        exp_ch = (pat == 2'b11) ? ~lg : pat[1];
        waited = 0;
        #1;
        while (req_ready == 2'b00 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("grant_seen", 32'(req_ready != 2'b00), 1);
        chk("grant_channel", 32'(req_ready), exp_ch ? 32'd2 : 32'd1);
        lg = exp_ch;
        @(posedge clk);
        #1 req_valid = after;
    endtask

    task automatic finish_job(input logic c, input logic [W-1:0] a, input logic [W-1:0] b, input int bp);
        logic [W-1:0] eq, er;
        logic [1:0]   ev;
        logic         dz, ok;
        int           lat, cyc;
        dz  = (b == '0);
        eq  = dz ? {W{1'b1}} : a / b;
        er  = dz ? a : a % b;
        lat = dz ? 2 : int'(eq) + 3;
        ev  = c ? 2'b10 : 2'b01;
        ok  = 1'b1;
        cyc = 0;
        while (cyc == 0 || (rsp_valid == 2'b00 && cyc < lat + 10)) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid == 2'b00)
                ok &= (busy === 1'b1) && (req_ready === 2'b00);
        end
        chk("busy_while_running", 32'(ok), 1);
        chk("latency", 32'(cyc), 32'(lat));
        chk("grant_id", 32'(grant_id), 32'(c));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("quotient", 32'(rsp_quotient), 32'(eq));
        chk("remainder", 32'(rsp_remainder), 32'(er));
        chk("divzero", 32'(rsp_divzero), 32'(dz));
        rsp_ready = ~ev;
        ok = 1'b1;
        repeat (bp) begin
            @(negedge clk);
            ok &= (rsp_valid === ev) && (rsp_quotient === eq) && (rsp_remainder === er)
                  && (req_ready === 2'b00) && (busy === 1'b1);
        end
        chk("held_under_backpressure", 32'(ok), 1);
        rsp_ready = ev;
        @(posedge clk);
        #1 rsp_ready = 2'b00;
        @(negedge clk);
        chk("rsp_valid_drop", 32'(rsp_valid), 0);
        chk("busy_drop", 32'(busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        lg = 1'b1;

        dvd0 = 16'd100; dvs0 = 16'd7; req_valid = 2'b01;
        wait_grant(2'b01, 2'b00, ch, w);
        finish_job(ch, 16'd100, 16'd7, 0);

        dvd1 = 16'd55; dvs1 = 16'd0; req_valid = 2'b10;
        wait_grant(2'b10, 2'b00, ch, w);
        finish_job(ch, 16'd55, 16'd0, 0);

        rst_n = 1'b0;
        dvd0 = 16'd20; dvs0 = 16'd4; dvd1 = 16'd9; dvs1 = 16'd3;
        req_valid = 2'b11;
        #1 chk("ready_in_reset", 32'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        lg = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_grant(2'b11, 2'b11, ch, w);
            finish_job(ch, ch ? 16'd9 : 16'd20, ch ? 16'd3 : 16'd4, 0);
        end
        req_valid = 2'b00;

        dvd0 = 16'd3; dvs0 = 16'd10; dvd1 = 16'd8; dvs1 = 16'd2;
        req_valid = 2'b01;
        wait_grant(2'b01, 2'b10, ch, w);
        finish_job(ch, 16'd3, 16'd10, 10);
        wait_grant(2'b10, 2'b00, ch, w);
        chk("grant_after_backpressure", 32'(w), 0);
        finish_job(ch, 16'd8, 16'd2, 0);

        dvd1 = 16'hFFFF; dvs1 = 16'hFFFF; req_valid = 2'b10;
        wait_grant(2'b10, 2'b00, ch, w);
        finish_job(ch, 16'hFFFF, 16'hFFFF, 0);
        dvd0 = 16'hFFFF; dvs0 = 16'd1; req_valid = 2'b01;
        wait_grant(2'b01, 2'b00, ch, w);
        finish_job(ch, 16'hFFFF, 16'd1, 0);

        for (int i = 0; i < 20; i++) begin
            logic [1:0]   pat;
            logic [W-1:0] a [2];
            logic [W-1:0] b [2];
            pat = 2'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++) begin
                a[k] = W'($urandom_range(0, 65535));
                b[k] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 65535));
                if (b[k] != '0 && a[k] / b[k] > 200)
                    b[k] = a[k] / 200 + 1'b1;
            end
            dvd0 = a[0]; dvs0 = b[0]; dvd1 = a[1]; dvs1 = b[1];
            req_valid = pat;
            wait_grant(pat, 2'b00, ch, w);
            finish_job(ch, a[ch], b[ch], int'($urandom_range(0, 3)));
        end

        dvd0 = 16'hFFFF; dvs0 = 16'd1; req_valid = 2'b01;
        wait_grant(2'b01, 2'b00, ch, w);
        repeat (50) @(negedge clk);
        dvd0 = 16'd20; dvs0 = 16'd4; dvd1 = 16'd9; dvs1 = 16'd3;
        req_valid = 2'b11;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        lg = 1'b1;
        wait_grant(2'b11, 2'b00, ch, w);
        finish_job(ch, ch ? 16'd9 : 16'd20, ch ? 16'd3 : 16'd4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
